adex_spike_monitor: RTL and testbench
=====================================

# adex_spike_monitor

Downstream consumer of the AdEx neuron core's one-cycle spike pulse. Measures inter-spike intervals (ISI) in clock cycles, buffers them in a small FIFO, and counts spikes per programmable window. ISI values are read out off-chip one nibble at a time through an edge-strobed port, mirroring the core's nibble-based parameter loader.

## Interface
- ISI_W, 16: ISI counter and FIFO entry width; must be a multiple of 4.
- FIFO_DEPTH, 4: number of ISI entries; power of two.
- BURST_ISI, 8: an ISI strictly below this value flags a burst.
- clk  in  1: single clock domain; all logic rises on posedge clk.
- rst_n  in  1: asynchronous, active-low reset; clears all state.
- enable  in  1: same signal as the core's enable. While low, counters freeze and spikes are ignored.
- clear  in  1: synchronous clear of FIFO, counters, overflow and first-spike flag; has priority over all other events.
- spike_in  in  1: core spike pulse, high for one cycle per spike.
- window_len  in  16: rate window length in enabled cycles; 0 disables the rate path.
- rd_strobe  in  1: nibble read strobe; acts on its rising edge.
- nib_out  out  4: currently selected nibble of the FIFO head entry.
- nib_valid  out  1: FIFO not empty.
- fifo_full  out  1: FIFO holds FIFO_DEPTH entries.
- overflow  out  1: sticky; set when a push is dropped.
- rate_count  out  8: spike count of the last completed window.
- rate_valid  out  1: one-cycle pulse when rate_count updates.
- burst  out  1: one-cycle pulse on a burst ISI push.

## Operation
- Reset values: nib_out=0, nib_valid=0, fifo_full=0, overflow=0, rate_count=0, rate_valid=0, burst=0. Nibble pointer=0. First-spike flag=0.
- ISI counter:
  - On an enabled spike cycle the counter loads 1.
  - Each subsequent enabled non-spike cycle it increments, saturating at all-ones.
  - An enabled spike with the first-spike flag set pushes the current counter value. Example: spikes at t and t+5 push 5.
  - The first spike after reset or clear only sets the flag; it pushes nothing.
- Burst: pushed ISI < BURST_ISI drives burst high for one cycle. This fires even if the push is dropped.
- FIFO behaviour:
  - Push while full and no pop in the same cycle: the value is dropped and overflow is set.
  - Push and pop in the same cycle while full: both are performed.
  - A pop while empty cannot happen (see readout).
- Readout:
  - A rising edge is rd_strobe high with its previous-cycle sample low.
  - nib_out shows the head entry nibble selected by the pointer, MSB nibble first (pointer 0 gives bits [ISI_W-1:ISI_W-4]).
  - Each rising edge while nib_valid=1 advances the pointer. The edge that moves the pointer past the last nibble pops the entry and wraps the pointer to 0.
  - Edges while the FIFO is empty are ignored.
- Rate window (window_len≠0):
  - A window counter counts enabled cycles, and a spike counter counts enabled spikes, saturating at 255.
  - On the cycle where the window counter equals window_len−1, the registered output does three things: rate_count takes the spike count, including a spike on that same cycle; the spike counter restarts at 0; the window counter restarts at 0.
  - Changing window_len mid-window takes effect at the next comparison. If the counter is already ≥ the new value, the window runs until the counter wraps.
- window_len=0: window and spike counters are held at 0, and rate_valid never fires.
- Clear: empties the FIFO, zeroes the pointer and all counters, and drops overflow and the first-spike flag. rate_count keeps its value.
- rst_n asserted mid-readout: the pointer resets, and a partially read entry is lost.

## Timing
- Spike at cycle t: nib_valid/fifo_full update at t+1, and burst pulses at t+1.
- Rising edge sampled at cycle n: the pointer, nib_out and pop take effect at n+1.
- rate_valid pulses in the cycle after the window's last cycle, together with the new rate_count.
- All outputs are registered except nib_out, which is a mux of registered head data and the registered pointer.

## Structure
- Shared package adex_pkg holds:
  - ISI_W, FIFO_DEPTH and the BURST_ISI default;
  - the nibble width constant (4);
  - the rate counter width (8).
- One sub-module, isi_fifo: synchronous FIFO with push, pop, full, empty and head data.
- Edge detection, the ISI counter, the rate window and the readout pointer stay in the top module.

## Test plan
- Reset, then enable=1 and spikes at cycles 10, 15, 35 → FIFO holds 5 and 20; burst fires only for 5. Reading with 8 strobes returns nibbles 0,0,0,5,0,0,1,4; nib_valid=0 afterwards.
- Six spikes 3 cycles apart with no reads (depth 4) → fifo_full=1 after the 5th spike. The 6th push is dropped, overflow=1, and the head entry is still 3.
- window_len=10 with spikes on window cycles 0, 4 and 9 → rate_valid pulses once with rate_count=3; the next window starts from 0.
- enable low for 50 cycles between spikes 4 enabled cycles apart → pushed ISI=4, and spikes during disable are ignored.
- Full FIFO, with a spike arriving in the same cycle as the 4th-nibble strobe edge → pop and push both occur, overflow stays 0, and 4 entries remain.
- rd_strobe held high for 20 cycles → exactly one nibble advance; clear mid-readout → nib_valid=0, pointer=0, rate_count unchanged.

Source files
------------

// File: rtl/adex_pkg.sv
// Shared constants for the AdEx spike monitor: default sizes and the fixed
// nibble and rate-counter widths.
package adex_pkg;

  localparam int unsigned ISI_W      = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BURST_ISI  = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned RATE_W     = 8;

endpackage

// File: rtl/adex_spike_monitor_if.sv
// Nibble readout port: the off-chip reader strobes, the monitor presents the
// selected nibble of the FIFO head.
interface adex_spike_monitor_if;
  import adex_pkg::*;

  logic             rd_strobe;
  logic [NIB_W-1:0] nib_out;
  logic             nib_valid;

  modport master (output rd_strobe, input nib_out, nib_valid);
  modport slave  (input rd_strobe, output nib_out, nib_valid);

endinterface

// File: rtl/isi_fifo.sv
// Synchronous FIFO of ISI entries. A push while full is only accepted when a
// pop happens in the same cycle.
module isi_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign head    = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/adex_spike_monitor.sv
// Spike monitor: measures inter-spike intervals, buffers them for nibble-wise
// readout, and counts spikes per programmable window.
module adex_spike_monitor #(
  parameter int unsigned ISI_W      = adex_pkg::ISI_W,
  parameter int unsigned FIFO_DEPTH = adex_pkg::FIFO_DEPTH,
  parameter int unsigned BURST_ISI  = adex_pkg::BURST_ISI
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        spike_in,
  input  logic [15:0]                 window_len,
  adex_spike_monitor_if.slave         rd_bus,
  output logic                        fifo_full,
  output logic                        overflow,
  output logic [adex_pkg::RATE_W-1:0] rate_count,
  output logic                        rate_valid,
  output logic                        burst
);
  import adex_pkg::*;

  localparam int unsigned NIBS  = ISI_W / NIB_W;
  localparam int unsigned PTR_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  logic              strobe_q, first_q, overflow_q, rate_valid_q, burst_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [ISI_W-1:0]  isi_q, head;
  logic [15:0]       win_q;
  logic [RATE_W-1:0] spk_q, spk_nxt, rate_count_q;
  logic              rise, spike_en, push, pop, last_nib, full, empty;
  logic [NIB_W-1:0]  nib;

  assign rise     = rd_bus.rd_strobe & ~strobe_q;
  assign spike_en = enable & spike_in;
  assign push     = spike_en & first_q & ~clear;
  assign last_nib = (ptr_q == PTR_W'(NIBS - 1));
  assign pop      = rise & ~empty & last_nib & ~clear;
  assign spk_nxt  = (spike_en && !(&spk_q)) ? spk_q + 1'b1 : spk_q;

  isi_fifo #(
    .WIDTH (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (isi_q),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // MSB nibble first: pointer 0 selects the top nibble.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (ptr_q == PTR_W'(i)) nib = head[ISI_W-1-NIB_W*i -: NIB_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q     <= 1'b0;
      ptr_q        <= '0;
      isi_q        <= '0;
      first_q      <= 1'b0;
      overflow_q   <= 1'b0;
      win_q        <= '0;
      spk_q        <= '0;
      rate_count_q <= '0;
      rate_valid_q <= 1'b0;
      burst_q      <= 1'b0;
    end else begin
      strobe_q     <= rd_bus.rd_strobe;
      rate_valid_q <= 1'b0;
      burst_q      <= 1'b0;
      if (clear) begin
        ptr_q      <= '0;
        isi_q      <= '0;
        first_q    <= 1'b0;
        overflow_q <= 1'b0;
        win_q      <= '0;
        spk_q      <= '0;
      end else begin
        if (rise && !empty) ptr_q <= last_nib ? '0 : ptr_q + 1'b1;
        if (spike_en) begin
          isi_q   <= ISI_W'(1);
          first_q <= 1'b1;
        end else if (enable && !(&isi_q)) begin
          isi_q <= isi_q + 1'b1;
        end
        // Burst is flagged from the measured interval even if the push is dropped.
        if (push) begin
          burst_q <= (isi_q < ISI_W'(BURST_ISI));
          if (full && !pop) overflow_q <= 1'b1;
        end
        if (window_len == '0) begin
          win_q <= '0;
          spk_q <= '0;
        end else if (enable) begin
          if (win_q == window_len - 16'd1) begin
            rate_count_q <= spk_nxt;
            rate_valid_q <= 1'b1;
            win_q        <= '0;
            spk_q        <= '0;
          end else begin
            win_q <= win_q + 16'd1;
            spk_q <= spk_nxt;
          end
        end
      end
    end
  end

  assign rd_bus.nib_out   = empty ? '0 : nib;
  assign rd_bus.nib_valid = ~empty;
  assign fifo_full        = full;
  assign overflow         = overflow_q;
  assign rate_count       = rate_count_q;
  assign rate_valid       = rate_valid_q;
  assign burst            = burst_q;

endmodule

// File: tb/tb_adex_spike_monitor.sv
// Bench for adex_spike_monitor: timestamp/queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_adex_spike_monitor;

  localparam int DEPTH = 4;
  localparam int NIBS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        spike_in = 1'b0;
  logic [15:0] window_len = '0;
  logic        fifo_full, overflow, rate_valid, burst;
  logic [7:0]  rate_count;

  adex_spike_monitor_if bus ();

  adex_spike_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rd_bus     (bus),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .rate_count (rate_count),
    .rate_valid (rate_valid),
    .burst      (burst)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int burst_seen = 0;
  int rate_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: ISIs are differences of enabled-cycle timestamps; FIFO is a queue.
  int     m_q[$];
  int     m_ptr = 0;
  bit     m_ovf = 0, m_first = 0, m_prev_rd = 0, m_rv = 0, m_burst = 0;
  longint m_en_time = 0, m_last = 0;
  int     m_win = 0, m_spk = 0, m_rate = 0;

  always @(posedge clk) begin
    bit rise, popped;
    int size0, isi, spk_new;
    if (!rst_n) begin
      m_q.delete();
      m_ptr = 0; m_ovf = 0; m_first = 0; m_prev_rd = 0; m_rv = 0; m_burst = 0;
      m_win = 0; m_spk = 0; m_rate = 0;
    end else begin
      rise = bus.rd_strobe && !m_prev_rd;
      m_prev_rd = bus.rd_strobe;
      m_rv = 0;
      m_burst = 0;
      if (clear) begin
        m_q.delete();
        m_ptr = 0; m_ovf = 0; m_first = 0; m_win = 0; m_spk = 0;
      end else begin
        popped = 0;
        size0 = m_q.size();
        if (rise && size0 > 0) begin
          m_ptr++;
          if (m_ptr == NIBS) begin
            void'(m_q.pop_front());
            m_ptr = 0;
            popped = 1;
          end
        end
        if (enable && spike_in) begin
          if (m_first) begin
            isi = (m_en_time - m_last > 65535) ? 65535 : int'(m_en_time - m_last);
            m_burst = (isi < 8);
            if (size0 < DEPTH || popped) m_q.push_back(isi);
            else m_ovf = 1;
          end
          m_first = 1;
          m_last = m_en_time;
        end
        if (window_len == 0) begin
          m_win = 0;
          m_spk = 0;
        end else if (enable) begin
          spk_new = m_spk + ((spike_in && m_spk < 255) ? 1 : 0);
          if (m_win == int'(window_len) - 1) begin
            m_rate = spk_new; m_rv = 1; m_win = 0; m_spk = 0;
          end else begin
            m_win = (m_win + 1) % 65536;
            m_spk = spk_new;
          end
        end
        if (enable) m_en_time++;
      end
    end
  end

  always @(posedge clk) begin
    int exp_nib;
    #1;
    exp_nib = (m_q.size() > 0) ? ((m_q[0] >> (4 * (NIBS - 1 - m_ptr))) & 15) : 0;
    chk("nib_valid", int'(bus.nib_valid), int'(m_q.size() > 0));
    chk("nib_out", int'(bus.nib_out), exp_nib);
    chk("fifo_full", int'(fifo_full), int'(m_q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("rate_count", int'(rate_count), m_rate);
    chk("rate_valid", int'(rate_valid), int'(m_rv));
    chk("burst", int'(burst), int'(m_burst));
    if (burst) burst_seen++;
    if (rate_valid) rate_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_spike();
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
  endtask

  task automatic spike_after(input int gap);
    cyc(gap - 1);
    pulse_spike();
  endtask

  task automatic strobe();
    bus.rd_strobe = 1'b1;
    @(negedge clk);
    bus.rd_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int exp_nibs[8] = '{0, 0, 0, 5, 0, 0, 1, 4};
  int b0, r0;

  initial begin
    bus.rd_strobe = 1'b0;
    cyc(3);
    chk("rst_nib_out", int'(bus.nib_out), 0);
    chk("rst_nib_valid", int'(bus.nib_valid), 0);
    chk("rst_fifo_full", int'(fifo_full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_rate_count", int'(rate_count), 0);
    chk("rst_rate_valid", int'(rate_valid), 0);
    chk("rst_burst", int'(burst), 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // Spikes at 10, 15, 35 -> ISIs 5 and 20, burst only for 5.
    cyc(9);
    pulse_spike();
    spike_after(5);
    spike_after(20);
    chk("t1_model_q0", m_q[0], 5);
    chk("t1_model_q1", m_q[1], 20);
    chk("t1_bursts", burst_seen, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_nib", int'(bus.nib_out), exp_nibs[i]);
      strobe();
    end
    chk("t1_empty", int'(bus.nib_valid), 0);

    // Six spikes 3 apart, no reads: full after the 5th, 6th dropped.
    do_clear();
    pulse_spike();
    for (int i = 0; i < 4; i++) spike_after(3);
    chk("t2_full", int'(fifo_full), 1);
    chk("t2_no_ovf", int'(overflow), 0);
    spike_after(3);
    chk("t2_ovf", int'(overflow), 1);
    chk("t2_model_head", m_q[0], 3);
    chk("t2_model_size", m_q.size(), 4);

    // Rate window of 10 with spikes on window cycles 0, 4, 9.
    r0 = rate_seen;
    clear = 1'b1;
    window_len = 16'd10;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_in = (i == 0 || i == 4 || i == 9);
      @(negedge clk);
    end
    spike_in = 1'b0;
    chk("t3_rate_valid", int'(rate_valid), 1);
    chk("t3_rate_count", int'(rate_count), 3);
    chk("t3_one_pulse", rate_seen - r0, 1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("t3_empty_window", int'(rate_count), 0);
    for (int i = 0; i < 10; i++) begin
      spike_in = (i == 2);
      @(negedge clk);
    end
    spike_in = 1'b0;
    chk("t3_third_window", int'(rate_count), 1);
    window_len = 16'd0;

    // Enable low 50 cycles between spikes 4 enabled cycles apart.
    do_clear();
    b0 = burst_seen;
    pulse_spike();
    cyc(1);
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      spike_in = (i % 7 == 3);
      @(negedge clk);
    end
    spike_in = 1'b0;
    enable = 1'b1;
    cyc(2);
    pulse_spike();
    chk("t4_model_size", m_q.size(), 1);
    chk("t4_model_isi", m_q[0], 4);
    chk("t4_valid", int'(bus.nib_valid), 1);
    chk("t4_burst", burst_seen - b0, 1);

    // Full FIFO, spike in the same cycle as the popping strobe edge.
    do_clear();
    pulse_spike();
    for (int i = 0; i < 4; i++) spike_after(3);
    chk("t5_full", int'(fifo_full), 1);
    for (int i = 0; i < 3; i++) strobe();
    bus.rd_strobe = 1'b1;
    spike_in = 1'b1;
    @(negedge clk);
    bus.rd_strobe = 1'b0;
    spike_in = 1'b0;
    @(negedge clk);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_full_after", int'(fifo_full), 1);
    chk("t5_model_size", m_q.size(), 4);

    // Held strobe advances once; then clear mid-readout.
    bus.rd_strobe = 1'b1;
    cyc(20);
    bus.rd_strobe = 1'b0;
    @(negedge clk);
    strobe();
    strobe();
    chk("t6_still_full", int'(fifo_full), 1);
    strobe();
    chk("t6_popped", int'(fifo_full), 0);
    strobe();
    do_clear();
    chk("t6_clear_valid", int'(bus.nib_valid), 0);
    chk("t6_rate_kept", int'(rate_count), 1);
    strobe();
    chk("t6_clear_ptr", int'(bus.nib_valid), 0);

    // Reset mid-readout drops the partially read entry.
    pulse_spike();
    spike_after(3);
    chk("t7_valid", int'(bus.nib_valid), 1);
    strobe();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("t7_reset_valid", int'(bus.nib_valid), 0);
    chk("t7_reset_rate", int'(rate_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
